display_cmd_sequencer: RTL and testbench
========================================

# display_cmd_sequencer

Avalon-MM front end for the sprite/tile display layers: it accepts 32-bit command words from software and buffers them in a FIFO. It drains them one per cycle onto the shared `writedata` command bus that every display component (block, sprite, background layers) decodes. It owns the double-buffer index, so it forces every write into the back buffer. It also turns a software "commit" into a single buffer-swap word issued at vertical-blank entry, so displayed state changes only between frames.

## Interface
Parameters:
- `FIFO_DEPTH`, 64: command FIFO entries; power of two.
- `VBLANK_LINE`, 480: `vcount` value marking vertical-blank entry.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: reset is synchronous and active-high.
- `chipselect` in 1: Avalon slave select.
- `write` in 1: Avalon write strobe.
- `read` in 1: Avalon read strobe.
- `address` in 2: 0 = command word, 1 = commit, 2 = clear flags; reads of any address return status.
- `writedata` in 32: Avalon write data.
- `readdata` out 32: status word.
- `hcount` in 10: current VGA pixel column.
- `vcount` in 10: current VGA line.
- `cmd_out` out 32: command bus to the display components, registered.

## Operation
- Command word format: `[31:26]` sub_comp, `[25:21]` child, `[20:17]` info, `[16:14]` type, `[13]` buffer select, `[12:0]` msg.
- Info codes: 0000 = NOP, 0001 = WRITE, 1111 = SWAP.
- FIFO entries are 33 bits, `{is_commit, word}`.
- Address 0 write pushes `{0, writedata}`.
- Address 1 write pushes `{1, 32'h0}`; the data value is ignored.
- Address 2 write clears the sticky flags.
- Push while FIFO full: the entry is dropped and `overflow` is set. Fullness is judged on the count at the start of the cycle; a same-cycle pop does not make room.
- `front` register: the buffer currently displayed.
- FSM states:
  - DRAIN: if the FIFO is non-empty, pop one entry per cycle. A data entry with info WRITE is emitted with bit 13 replaced by `~front`. A data entry with info SWAP is emitted as NOP (all zero) and sets `illegal`. Any other info is emitted unchanged. A commit entry is emitted as NOP and moves the FSM to WAIT_VBL. If the FIFO is empty, emit NOP.
  - WAIT_VBL: no pops; FIFO pushes are still accepted. `cmd_out` is NOP. Vblank entry is when `vcount == VBLANK_LINE` and the registered previous `vcount != VBLANK_LINE`; on vblank entry go to SWAP.
  - SWAP: emit the swap word for one cycle: all fields 0 except info = 1111 and bit 13 = `~front`. Toggle `front` and return to DRAIN.
- `cmd_out` is NOP on every cycle that carries no command; components act on `cmd_out` every cycle.
- Status word on `readdata` (combinational from registers, zero read latency):
  - `[14:8]` FIFO level.
  - `[3]` `illegal`.
  - `[2]` `overflow`.
  - `[1]` in WAIT_VBL.
  - `[0]` `front`.
  - All other bits 0.
- `hcount` is unused beyond port completeness; vblank detection uses `vcount` only.

## Timing
- Reset values: `cmd_out` = 0 (NOP), `front` = 0, FIFO empty, flags 0, state DRAIN, previous-`vcount` register = 0. A reset mid-operation discards FIFO contents and any pending commit.
- Latency: a word pushed at cycle t into an empty FIFO in DRAIN appears on `cmd_out` at t+2. A full FIFO drains one word per cycle.
- A commit popped at cycle t puts NOP on `cmd_out` at t+1. The swap word appears the cycle after the vblank-entry cycle, plus one register stage: edge detected at cycle v, state SWAP at v+1, swap word on `cmd_out` at v+2. Draining resumes with the first pop at v+2, whose word appears at v+3.
- If vblank entry occurs during DRAIN, it is ignored; a commit arriving afterwards waits a full frame.
- A simultaneous push and pop on a non-full FIFO is legal; the level stays unchanged.

## Structure
- Shared package `display_pkg` holds:
  - the field offsets and widths above;
  - `INFO_NOP`, `INFO_WRITE`, `INFO_SWAP`;
  - the 33-bit FIFO entry typedef;
  - the FSM state enum.
- One sub-module `cmd_sync_fifo`: parameterized depth and width, synchronous reset, `full`/`empty`/`level` outputs, first-word-fall-through read.

## Test plan
- Reset, then push WRITE word `32'h1C02_4000` (sub 7, child 0, info 0001, type 001, bit13 = 0) at cycle 10 → `cmd_out` = `32'h1C02_6000` at cycle 12 (bit 13 = `~front` = 1); NOP at all other cycles.
- Push 3 words, then a commit; hold `vcount` = 100 → 3 words emitted, then NOP, status bit1 = 1. Step `vcount` to 480 → `cmd_out` = `32'h001E_2000` exactly once, then `front` = 1 and status `[1:0]` = 2'b01.
- During WAIT_VBL push 2 WRITE words → not emitted before the swap word; both emitted after it with bit 13 = 0.
- Fill 64 entries with no draining (stall in WAIT_VBL), then push a 65th → dropped, status bit2 = 1, level = 64. A write to address 2 clears bit 2.
- Push a word with info = 1111 → NOP emitted in its slot, `illegal` set, `front` unchanged.
- Assert reset while in WAIT_VBL with 5 entries queued → next cycle: level 0, `front` 0, `cmd_out` NOP, and no swap word at the next vblank.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display command path: command word layout,
// info codes, FIFO entry format and sequencer states.
package display_pkg;

    localparam int CMD_W     = 32;
    localparam int SUB_LSB   = 26;
    localparam int SUB_W     = 6;
    localparam int CHILD_LSB = 21;
    localparam int CHILD_W   = 5;
    localparam int INFO_LSB  = 17;
    localparam int INFO_W    = 4;
    localparam int TYPE_LSB  = 14;
    localparam int TYPE_W    = 3;
    localparam int BUF_BIT   = 13;
    localparam int MSG_LSB   = 0;
    localparam int MSG_W     = 13;

    localparam logic [INFO_W-1:0] INFO_NOP   = 4'b0000;
    localparam logic [INFO_W-1:0] INFO_WRITE = 4'b0001;
    localparam logic [INFO_W-1:0] INFO_SWAP  = 4'b1111;

    localparam logic [CMD_W-1:0] CMD_NOP = '0;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_COMMIT = 2'd1;
    localparam logic [1:0] ADDR_CLEAR  = 2'd2;

    typedef struct packed {
        logic             is_commit;
        logic [CMD_W-1:0] word;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    typedef enum logic [1:0] {
        ST_DRAIN    = 2'd0,
        ST_WAIT_VBL = 2'd1,
        ST_SWAP     = 2'd2
    } seq_state_e;

    function automatic logic [INFO_W-1:0] cmd_info(input logic [CMD_W-1:0] word);
        return word[INFO_LSB +: INFO_W];
    endfunction

    function automatic logic [CMD_W-1:0] with_buf(input logic [CMD_W-1:0] word,
                                                  input logic             buf_sel);
        logic [CMD_W-1:0] w;
        w          = word;
        w[BUF_BIT] = buf_sel;
        return w;
    endfunction

    function automatic logic [CMD_W-1:0] swap_word(input logic buf_sel);
        logic [CMD_W-1:0] w;
        w                       = CMD_NOP;
        w[INFO_LSB +: INFO_W]   = INFO_SWAP;
        w[BUF_BIT]              = buf_sel;
        return w;
    endfunction

endpackage

// File: rtl/cmd_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read. A push into a full
// FIFO is discarded; fullness is judged before any same-cycle pop.
module cmd_sync_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/display_cmd_sequencer.sv
// Avalon-MM command front end: buffers software command words, drains them
// onto the shared display command bus and issues buffer swaps at vblank.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_DRAIN    | pop one FIFO entry per cycle onto cmd_out
//   ST_WAIT_VBL | commit seen; hold the FIFO until vertical-blank entry
//   ST_SWAP     | emit the buffer-swap word and flip the front buffer
module display_cmd_sequencer
    import display_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int VBLANK_LINE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out
);

    localparam int         LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [9:0] VBL_LINE = 10'(VBLANK_LINE);

    seq_state_e       state;
    seq_state_e       state_next;

    fifo_entry_t      push_entry;
    fifo_entry_t      head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    logic             wr_cmd;
    logic             wr_commit;
    logic             wr_clear;

    logic             front;
    logic             illegal;
    logic             overflow;
    logic [9:0]       vcount_prev;
    logic             vbl_entry;

    logic [CMD_W-1:0] cmd_next;
    logic             set_illegal;
    logic             toggle_front;

    // Pixel column and read strobe play no part: status is always driven.
    logic             unused_inputs;
    assign unused_inputs = ^{hcount, read};

    assign wr_cmd    = chipselect && write && (address == ADDR_CMD);
    assign wr_commit = chipselect && write && (address == ADDR_COMMIT);
    assign wr_clear  = chipselect && write && (address == ADDR_CLEAR);
    assign fifo_push = wr_cmd || wr_commit;

    always_comb begin
        push_entry = '{is_commit: 1'b0, word: writedata};
        if (wr_commit) begin
            push_entry = '{is_commit: 1'b1, word: CMD_NOP};
        end
    end

    cmd_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign vbl_entry = (vcount == VBL_LINE) && (vcount_prev != VBL_LINE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_DRAIN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_DRAIN: begin
                if (!fifo_empty && head.is_commit) begin
                    state_next = ST_WAIT_VBL;
                end
            end
            ST_WAIT_VBL: begin
                if (vbl_entry) begin
                    state_next = ST_SWAP;
                end
            end
            ST_SWAP: begin
                state_next = ST_DRAIN;
            end
            default: begin
                state_next = ST_DRAIN;
            end
        endcase
    end

    always_comb begin
        fifo_pop     = 1'b0;
        cmd_next     = CMD_NOP;
        set_illegal  = 1'b0;
        toggle_front = 1'b0;
        case (state)
            ST_DRAIN: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (!head.is_commit) begin
                        case (cmd_info(head.word))
                            INFO_WRITE: cmd_next    = with_buf(head.word, ~front);
                            INFO_SWAP:  set_illegal = 1'b1;
                            default:    cmd_next    = head.word;
                        endcase
                    end
                end
            end
            ST_SWAP: begin
                cmd_next     = swap_word(~front);
                toggle_front = 1'b1;
            end
            default: begin
                cmd_next = CMD_NOP;
            end
        endcase
    end

    // A flag raised in the same cycle as a clear wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_out     <= CMD_NOP;
            front       <= 1'b0;
            illegal     <= 1'b0;
            overflow    <= 1'b0;
            vcount_prev <= '0;
        end else begin
            cmd_out     <= cmd_next;
            front       <= front ^ toggle_front;
            vcount_prev <= vcount;
            if (wr_clear) begin
                illegal  <= 1'b0;
                overflow <= 1'b0;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (fifo_push && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        readdata       = '0;
        readdata[14:8] = 7'(fifo_level);
        readdata[3]    = illegal;
        readdata[2]    = overflow;
        readdata[1]    = (state == ST_WAIT_VBL);
        readdata[0]    = front;
    end

endmodule

// File: tb/tb_display_cmd_sequencer.sv
// Randomized and directed bench for display_cmd_sequencer with a queue-based
// reference model; a negedge monitor checks cmd_out and status every cycle.
module tb_display_cmd_sequencer;

    localparam int DEPTH = 64;
    localparam logic [9:0] VBL = 10'd480;

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] cmd_out;

    display_cmd_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .VBLANK_LINE (480)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .hcount     (hcount),
        .vcount     (vcount),
        .cmd_out    (cmd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] status;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [32:0] mq[$];
    logic        m_front;
    logic        m_ill;
    logic        m_ovf;
    int          m_phase;   // 0 draining, 1 waiting for vblank, 2 swap due
    logic [9:0]  m_prev_v;
    int          cycle_no;
    int          tests;
    int          fails;

    // Reference: one bus cycle of the sequencer described in plain terms.
    task automatic model_cycle();
        exp_t        e;
        logic [31:0] out;
        logic [32:0] ent;
        logic [3:0]  inf;
        logic        vbl;
        logic        raise_ill;
        int          lvl0;
        out       = 32'h0;
        raise_ill = 1'b0;
        if (reset) begin
            mq.delete();
            m_front  = 1'b0;
            m_ill    = 1'b0;
            m_ovf    = 1'b0;
            m_phase  = 0;
            m_prev_v = 10'd0;
        end else begin
            lvl0 = mq.size();
            vbl  = (vcount == VBL) && (m_prev_v != VBL);
            if (m_phase == 2) begin
                out     = 32'h001E_0000 | (m_front ? 32'h0 : 32'h0000_2000);
                m_front = !m_front;
                m_phase = 0;
            end else if (m_phase == 1) begin
                if (vbl) m_phase = 2;
            end else if (lvl0 > 0) begin
                ent = mq.pop_front();
                if (ent[32]) begin
                    m_phase = 1;
                end else begin
                    inf = ent[20:17];
                    if (inf == 4'b0001)
                        out = m_front ? (ent[31:0] & ~32'h0000_2000) : (ent[31:0] | 32'h0000_2000);
                    else if (inf == 4'b1111)
                        raise_ill = 1'b1;
                    else
                        out = ent[31:0];
                end
            end
            if (chipselect && write) begin
                if (address == 2'd0 || address == 2'd1) begin
                    if (lvl0 >= DEPTH) m_ovf = 1'b1;
                    else mq.push_back((address == 2'd1) ? {1'b1, 32'h0} : {1'b0, writedata});
                end else if (address == 2'd2) begin
                    m_ill = 1'b0;
                    m_ovf = 1'b0;
                end
            end
            if (raise_ill) m_ill = 1'b1;
            m_prev_v = vcount;
        end
        e.cmd    = out;
        e.status = {17'b0, 7'(mq.size()), 4'b0, m_ill, m_ovf, (m_phase == 1), m_front};
        e.cyc    = cycle_no;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic rst, input logic cs, input logic wr,
                       input logic [1:0] a, input logic [31:0] d);
        reset      = rst;
        chipselect = cs;
        write      = wr;
        address    = a;
        writedata  = d;
        read       = cs && !wr && ($urandom_range(0, 1) == 1);
        hcount     = 10'($urandom_range(0, 799));
        model_cycle();
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic push_word(input logic [31:0] w);
        cyc(1'b0, 1'b1, 1'b1, 2'd0, w);
    endtask

    task automatic push_commit();
        cyc(1'b0, 1'b1, 1'b1, 2'd1, $urandom);
    endtask

    task automatic clear_flags();
        cyc(1'b0, 1'b1, 1'b1, 2'd2, $urandom);
    endtask

    function automatic logic [31:0] rand_word(input int kind);
        logic [31:0] w;
        w = $urandom;
        case (kind)
            0:       w[20:17] = 4'b0001;
            1:       w[20:17] = 4'b1111;
            2:       w[20:17] = 4'b0000;
            default: w[20:17] = 4'($urandom_range(0, 15));
        endcase
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (cmd_out !== e.cmd) begin
                fails++;
                $display("FAIL cmd_out @cycle %0d: got %h, expected %h", e.cyc, cmd_out, e.cmd);
            end
            tests++;
            if (readdata !== e.status) begin
                fails++;
                $display("FAIL status @cycle %0d: got %h, expected %h", e.cyc, readdata, e.status);
            end
        end
    end

    initial begin
        int r;
        int vline;
        tests      = 0;
        fails      = 0;
        cycle_no   = 0;
        m_front    = 1'b0;
        m_ill      = 1'b0;
        m_ovf      = 1'b0;
        m_phase    = 0;
        m_prev_v   = 10'd0;
        vcount     = 10'd100;

        // Reset, then a single WRITE word
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        idle(7);
        push_word(32'h1C02_4000);
        idle(5);

        // Three words and a commit, two more words while waiting, then vblank
        push_word(rand_word(0));
        push_word(rand_word(2));
        push_word(rand_word(3));
        push_commit();
        idle(6);
        push_word(rand_word(0));
        push_word(rand_word(0));
        idle(3);
        vcount = VBL;
        idle(4);
        vcount = 10'd100;
        idle(4);

        // Vblank seen while draining is ignored; a later commit waits
        vcount = VBL;
        idle(2);
        vcount = 10'd101;
        push_commit();
        idle(4);

        // Stalled: fill to capacity, overflow on the 65th, then clear
        for (int i = 0; i < DEPTH + 1; i++) push_word(rand_word(i % 4));
        idle(2);
        clear_flags();
        idle(2);
        vcount = VBL;
        idle(2);
        vcount = 10'd100;
        idle(DEPTH + 6);

        // Illegal SWAP info from software
        push_word(rand_word(1));
        idle(3);
        clear_flags();
        idle(2);

        // Reset while waiting with five entries queued
        push_commit();
        for (int i = 0; i < 5; i++) push_word(rand_word(0));
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        idle(2);
        vcount = VBL;
        idle(3);
        vcount = 10'd100;
        idle(3);

        // Randomized traffic with a free-running short frame
        vline = 0;
        for (int i = 0; i < 3000; i++) begin
            vline  = (vline + 1) % 600;
            vcount = 10'(vline);
            r = $urandom_range(0, 99);
            if (r < 40)      push_word(rand_word($urandom_range(0, 4)));
            else if (r < 44) push_commit();
            else if (r < 46) clear_flags();
            else if (r < 47) cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
            else if (r < 49) cyc(1'b0, 1'b1, 1'b1, 2'd3, $urandom);
            else             cyc(1'b0, $urandom_range(0, 1) == 1, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
        end
        idle(2);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_check: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
